// File: rtl/lock_pkg.sv
// Shared constants for the digital lock: gateStatus encodings, digit/code widths,
// and a helper that writes one digit into the partial entry buffer.
package lock_pkg;

   localparam int DIGIT_W = 4;
   localparam int CODE_W  = 16;
   localparam int ENTRY_W = CODE_W - DIGIT_W;

   typedef enum logic [2:0] {
      ST_FAIL    = 3'd1,
      ST_LOCKED  = 3'd2,
      ST_ENTER   = 3'd3,
      ST_OPEN    = 3'd4,
      ST_SETCODE = 3'd5,
      ST_ALARM   = 3'd6
   } gateState_e;

   // Only the first three digits are buffered; the fourth is taken straight from the switches.
   function automatic logic [ENTRY_W-1:0] insertDigit(input logic [ENTRY_W-1:0] entry,
                                                      input logic [1:0]         slot,
                                                      input logic [DIGIT_W-1:0] digit);
      logic [ENTRY_W-1:0] result;
      result = entry;
      case (slot)
         2'd0:    result[11:8] = digit;
         2'd1:    result[7:4]  = digit;
         default: result[3:0]  = digit;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// 32-bit loadable down-counter shared by the timed lock states; holds at zero.
module lock_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] loadValue,
   output logic        zero
);

   logic [31:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= loadValue;
      else if (count != '0)
         count <= count - 32'd1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Central FSM of the digital lock: code entry, open/relock, code programming, fail/alarm timing.
// Build option: define LOCK_IDLE_TIMEOUT_EN to abandon ENTER/SETCODE after IDLE_CYCLES of inactivity.
//
// state      | meaning
// FAIL    1  | wrong code, lockout for FAIL_CYCLES
// LOCKED  2  | idle, waiting for btn_enter
// ENTER   3  | collecting the four code digits
// OPEN    4  | unlocked, auto-relocks after OPEN_CYCLES
// SETCODE 5  | collecting a new combination
// ALARM   6  | too many wrong codes, lockout for ALARM_CYCLES
module lock_sequencer
   import lock_pkg::*;
#(
   parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234,
   parameter int unsigned       MAX_TRIES    = 3,
   parameter int unsigned       FAIL_CYCLES  = 50_000_000,
   parameter int unsigned       ALARM_CYCLES = 500_000_000,
   parameter int unsigned       OPEN_CYCLES  = 250_000_000,
   parameter int unsigned       IDLE_CYCLES  = 500_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] switches,
   input  logic               btn_enter,
   input  logic               btn_set,
   output logic [2:0]         gateStatus,
   output logic [1:0]         currentIndex,
   output logic [DIGIT_W-1:0] currentDigit,
   output logic               unlocked,
   output logic               alarm
);

   localparam logic [31:0] FAIL_LOAD  = 32'(FAIL_CYCLES - 1);
   localparam logic [31:0] ALARM_LOAD = 32'(ALARM_CYCLES - 1);
   localparam logic [31:0] OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
   localparam logic [31:0] IDLE_LOAD  = 32'(IDLE_CYCLES - 1);

   gateState_e          state;
   logic [CODE_W-1:0]   storedCode;
   logic [ENTRY_W-1:0]  entry;
   logic [2:0]          tries;
   logic [CODE_W-1:0]   fullEntry;
   logic                lastDigit;
   logic                codeMatch;
   logic                lastTry;
   logic                timerLoad;
   logic [31:0]         timerValue;
   logic                timerZero;

   assign fullEntry  = {entry, switches};
   assign lastDigit  = btn_enter && (currentIndex == 2'd3);
   assign codeMatch  = (fullEntry == storedCode);
   assign lastTry    = ((tries + 3'd1) == 3'(MAX_TRIES));
   assign gateStatus = state;

   // The timer must be loaded on the same edge the state changes, so the load strobe
   // mirrors the FSM's transition conditions. In ENTER/SETCODE the idle value is always
   // loaded; it only has an effect when the idle timeout is built in.
   always_comb begin
      timerLoad  = 1'b0;
      timerValue = '0;
      case (state)
         ST_LOCKED: begin
            if (btn_enter) begin
               timerLoad  = 1'b1;
               timerValue = IDLE_LOAD;
            end
         end
         ST_ENTER: begin
            if (lastDigit) begin
               timerLoad  = 1'b1;
               timerValue = codeMatch ? OPEN_LOAD : (lastTry ? ALARM_LOAD : FAIL_LOAD);
            end else if (btn_enter) begin
               timerLoad  = 1'b1;
               timerValue = IDLE_LOAD;
            end
         end
         ST_OPEN: begin
            if (btn_set) begin
               timerLoad  = 1'b1;
               timerValue = IDLE_LOAD;
            end else if (btn_enter || timerZero) begin
               timerLoad  = 1'b1;
            end
         end
         ST_SETCODE: begin
            if (btn_enter) begin
               timerLoad  = 1'b1;
               timerValue = lastDigit ? 32'd0 : IDLE_LOAD;
            end else if (btn_set) begin
               timerLoad  = 1'b1;
               timerValue = OPEN_LOAD;
            end
         end
         default: ;
      endcase
   end

   lock_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (timerLoad),
      .loadValue (timerValue),
      .zero      (timerZero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_LOCKED;
         currentIndex <= '0;
         currentDigit <= '0;
         unlocked     <= 1'b0;
         alarm        <= 1'b0;
         storedCode   <= DEFAULT_CODE;
         tries        <= '0;
         entry        <= '0;
      end else begin
         case (state)
            ST_LOCKED: begin
               if (btn_enter) begin
                  state        <= ST_ENTER;
                  currentIndex <= '0;
                  entry        <= '0;
               end
            end
            ST_ENTER, ST_SETCODE: begin
               currentDigit <= switches;
               if (btn_enter) begin
                  if (currentIndex == 2'd3) begin
                     currentIndex <= '0;
                     if (state == ST_SETCODE) begin
                        storedCode <= fullEntry;
                        state      <= ST_LOCKED;
                     end else if (codeMatch) begin
                        state    <= ST_OPEN;
                        unlocked <= 1'b1;
                        tries    <= '0;
                     end else if (lastTry) begin
                        state <= ST_ALARM;
                        alarm <= 1'b1;
                        tries <= '0;
                     end else begin
                        state <= ST_FAIL;
                        tries <= tries + 3'd1;
                     end
                  end else begin
                     entry        <= insertDigit(entry, currentIndex, switches);
                     currentIndex <= currentIndex + 2'd1;
                  end
               end else if (state == ST_SETCODE && btn_set) begin
                  state        <= ST_OPEN;
                  unlocked     <= 1'b1;
                  currentIndex <= '0;
               end
`ifdef LOCK_IDLE_TIMEOUT_EN
               else if (timerZero) begin
                  state        <= ST_LOCKED;
                  currentIndex <= '0;
               end
`endif
            end
            ST_FAIL: begin
               if (timerZero)
                  state <= ST_LOCKED;
            end
            ST_ALARM: begin
               if (timerZero) begin
                  state <= ST_LOCKED;
                  alarm <= 1'b0;
               end
            end
            ST_OPEN: begin
               if (btn_set) begin
                  state        <= ST_SETCODE;
                  currentIndex <= '0;
                  entry        <= '0;
                  unlocked     <= 1'b0;
               end else if (btn_enter || timerZero) begin
                  state    <= ST_LOCKED;
                  unlocked <= 1'b0;
               end
            end
            default: begin
               state        <= ST_LOCKED;
               currentIndex <= '0;
               unlocked     <= 1'b0;
               alarm        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a digit-level reference model checked every cycle.
module tb_lock_sequencer;

   localparam int FAIL_C  = 4;
   localparam int ALARM_C = 8;
   localparam int OPEN_C  = 16;
   localparam int IDLE_C  = 20;
   localparam int TRIES   = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] switches = 4'd0;
   logic       btn_enter = 1'b0;
   logic       btn_set = 1'b0;
   logic [2:0] gateStatus;
   logic [1:0] currentIndex;
   logic [3:0] currentDigit;
   logic       unlocked;
   logic       alarm;

   lock_sequencer #(
      .DEFAULT_CODE (16'h1234),
      .MAX_TRIES    (TRIES),
      .FAIL_CYCLES  (FAIL_C),
      .ALARM_CYCLES (ALARM_C),
      .OPEN_CYCLES  (OPEN_C),
      .IDLE_CYCLES  (IDLE_C)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .switches     (switches),
      .btn_enter    (btn_enter),
      .btn_set      (btn_set),
      .gateStatus   (gateStatus),
      .currentIndex (currentIndex),
      .currentDigit (currentDigit),
      .unlocked     (unlocked),
      .alarm        (alarm)
   );

   always #5 clk = ~clk;

   int nCompared = 0;
   int nFailed   = 0;
   bit checkEn   = 1'b0;

   // Model: state code, slot, shown digit, stored and typed digits, tries, cycles left in state.
   int mState, mIdx, mDigit, mTries, mLeft;
   int mCode[4];
   int mEnt[4];

   function automatic void cmp(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nFailed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endfunction

   function automatic void modelStep();
      int  sw;
      bit  same;
      sw = int'(switches);
      if (reset) begin
         mState = 2; mIdx = 0; mDigit = 0; mTries = 0; mLeft = 0;
         mCode = '{1, 2, 3, 4};
         mEnt  = '{0, 0, 0, 0};
         return;
      end
      case (mState)
         2: if (btn_enter) begin
               mState = 3; mIdx = 0; mEnt = '{0, 0, 0, 0}; mLeft = IDLE_C;
            end
         3, 5: begin
            mDigit = sw;
            if (btn_enter) begin
               if (mIdx < 3) begin
                  mEnt[mIdx] = sw; mIdx++; mLeft = IDLE_C;
               end else begin
                  same = (mEnt[0] == mCode[0]) && (mEnt[1] == mCode[1]) &&
                         (mEnt[2] == mCode[2]) && (sw == mCode[3]);
                  mIdx = 0;
                  if (mState == 5) begin
                     mCode  = '{mEnt[0], mEnt[1], mEnt[2], sw};
                     mState = 2;
                  end else if (same) begin
                     mState = 4; mLeft = OPEN_C; mTries = 0;
                  end else if (mTries + 1 == TRIES) begin
                     mState = 6; mLeft = ALARM_C; mTries = 0;
                  end else begin
                     mTries++; mState = 1; mLeft = FAIL_C;
                  end
               end
            end else if (mState == 5 && btn_set) begin
               mState = 4; mIdx = 0; mLeft = OPEN_C;
            end
`ifdef LOCK_IDLE_TIMEOUT_EN
            else if (mLeft <= 1) begin
               mState = 2; mIdx = 0;
            end else
               mLeft--;
`endif
         end
         1, 6: if (mLeft <= 1) mState = 2; else mLeft--;
         4: begin
            if (btn_set) begin
               mState = 5; mIdx = 0; mEnt = '{0, 0, 0, 0}; mLeft = IDLE_C;
            end else if (btn_enter || mLeft <= 1)
               mState = 2;
            else
               mLeft--;
         end
         default: mState = 2;
      endcase
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         cmp("gateStatus",   int'(gateStatus),   mState);
         cmp("currentIndex", int'(currentIndex), mIdx);
         cmp("currentDigit", int'(currentDigit), mDigit);
         cmp("unlocked",     int'(unlocked),     int'(mState == 4));
         cmp("alarm",        int'(alarm),        int'(mState == 6));
      end
   end

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      #1;
   endtask

   task automatic press(input logic e, input logic s, input logic [3:0] d);
      switches  = d;
      btn_enter = e;
      btn_set   = s;
      tick();
      btn_enter = 1'b0;
      btn_set   = 1'b0;
   endtask

   task automatic tryCode(input logic [15:0] c);
      press(1'b1, 1'b0, 4'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         press(1'b1, 1'b0, c[15-4*i -: 4]);
         if (i < 3) tick();
      end
   endtask

   task automatic countState(input int st, output int n);
      n = 0;
      while (int'(gateStatus) == st && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      tick();
      checkEn = 1'b1;
      tick();
      cmp("rst_gate",     int'(gateStatus),   2);
      cmp("rst_index",    int'(currentIndex), 0);
      cmp("rst_digit",    int'(currentDigit), 0);
      cmp("rst_unlocked", int'(unlocked),     0);
      cmp("rst_alarm",    int'(alarm),        0);
      reset = 1'b0;
      tick();

      // Correct default code, with ignored btn_set in LOCKED and ENTER
      press(1'b0, 1'b1, 4'd0);
      cmp("locked_ignores_set", int'(gateStatus), 2);
      press(1'b1, 1'b0, 4'd0);
      cmp("enter_gate", int'(gateStatus), 3);
      cmp("enter_idx0", int'(currentIndex), 0);
      press(1'b1, 1'b0, 4'd1);
      cmp("idx_after_1", int'(currentIndex), 1);
      press(1'b0, 1'b1, 4'd7);
      cmp("enter_ignores_set", int'(gateStatus), 3);
      cmp("digit_follows_sw", int'(currentDigit), 7);
      press(1'b1, 1'b0, 4'd2);
      cmp("idx_after_2", int'(currentIndex), 2);
      press(1'b1, 1'b0, 4'd3);
      cmp("idx_after_3", int'(currentIndex), 3);
      press(1'b1, 1'b0, 4'd4);
      cmp("open_gate", int'(gateStatus), 4);
      cmp("open_unlocked", int'(unlocked), 1);
      countState(4, n);
      cmp("open_len", n, 16);
      cmp("relock_gate", int'(gateStatus), 2);

      // Three wrong codes: two FAIL lockouts then ALARM
      for (int k = 0; k < 2; k++) begin
         tryCode(16'h1235);
         cmp("fail_gate", int'(gateStatus), 1);
         countState(1, n);
         cmp("fail_len", n, 4);
      end
      tryCode(16'h1235);
      cmp("alarm_gate", int'(gateStatus), 6);
      cmp("alarm_out", int'(alarm), 1);
      n = 0;
      while (int'(gateStatus) == 6 && n < 200) begin
         btn_enter = n[0];
         btn_set   = ~n[0];
         tick();
         n++;
      end
      btn_enter = 1'b0;
      btn_set   = 1'b0;
      cmp("alarm_len", n, 8);
      cmp("after_alarm_gate", int'(gateStatus), 2);
      tryCode(16'h1235);
      cmp("tries_cleared", int'(gateStatus), 1);
      countState(1, n);

      // Program 9876
      tryCode(16'h1234);
      press(1'b0, 1'b1, 4'd0);
      cmp("setcode_gate", int'(gateStatus), 5);
      press(1'b1, 1'b0, 4'd9); press(1'b1, 1'b0, 4'd8);
      press(1'b1, 1'b0, 4'd7); press(1'b1, 1'b0, 4'd6);
      cmp("setcode_store", int'(gateStatus), 2);
      tryCode(16'h1234);
      cmp("old_code_fails", int'(gateStatus), 1);
      countState(1, n);
      tryCode(16'h9876);
      cmp("new_code_opens", int'(gateStatus), 4);
      press(1'b1, 1'b0, 4'd0);
      cmp("open_enter_relock", int'(gateStatus), 2);

      // SETCODE abort reloads the OPEN timer and keeps the code
      tryCode(16'h9876);
      press(1'b0, 1'b1, 4'd0);
      press(1'b1, 1'b0, 4'd5);
      press(1'b0, 1'b1, 4'd0);
      cmp("abort_open", int'(gateStatus), 4);
      countState(4, n);
      cmp("abort_open_len", n, 16);

      // Simultaneous pulses: btn_set wins in OPEN, btn_enter wins in SETCODE
      tryCode(16'h9876);
      cmp("still_9876", int'(gateStatus), 4);
      press(1'b1, 1'b1, 4'd0);
      cmp("both_open_to_set", int'(gateStatus), 5);
      press(1'b1, 1'b0, 4'd1); press(1'b1, 1'b0, 4'd1); press(1'b1, 1'b0, 4'd1);
      press(1'b1, 1'b1, 4'd1);
      cmp("both_setcode_store", int'(gateStatus), 2);
      tryCode(16'h1111);
      cmp("code_1111_opens", int'(gateStatus), 4);
      press(1'b1, 1'b0, 4'd0);

      // Reset mid-entry restores the default code
      press(1'b1, 1'b0, 4'd0);
      press(1'b1, 1'b0, 4'd1);
      press(1'b1, 1'b0, 4'd2);
      cmp("mid_idx", int'(currentIndex), 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cmp("reset_mid_gate", int'(gateStatus), 2);
      cmp("reset_mid_idx", int'(currentIndex), 0);
      tryCode(16'h1234);
      cmp("default_restored", int'(gateStatus), 4);
      press(1'b1, 1'b0, 4'd0);

`ifdef LOCK_IDLE_TIMEOUT_EN
      tryCode(16'h4321);
      countState(1, n);
      press(1'b1, 1'b0, 4'd0);
      press(1'b1, 1'b0, 4'd5);
      press(1'b1, 1'b0, 4'd6);
      countState(3, n);
      cmp("idle_len", n, 20);
      cmp("idle_gate", int'(gateStatus), 2);
      tryCode(16'h4321);
      cmp("tries_kept_fail", int'(gateStatus), 1);
      countState(1, n);
      tryCode(16'h4321);
      cmp("tries_kept_alarm", int'(gateStatus), 6);
      countState(6, n);
`endif

      repeat (3) tick();
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
